// File: rtl/fabric_xfer_pkg.sv
// Shared types and constants for the fabric transfer engine.
// Holds the FSM state enum, ctrl bit positions and default region bases.
package fabric_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    LD_UNPACK,
    RUN,
    ST_GATHER,
    ST_REQ,
    ST_WAIT
  } state_e;

  localparam int CTRL_RUN  = 31;
  localparam int CTRL_LOAD = 30;
  localparam int CTRL_BUSY = 29;
  localparam int CTRL_SY   = 10;
  localparam int CTRL_SX   = 0;

  localparam logic [31:0] MAP_BASE_DFLT = 32'h4000_0000;
  localparam logic [31:0] DIR_BASE_DFLT = 32'h4000_2000;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fabric_xfer_if.sv
// Memory bus between the transfer engine (master) and memory (slave).
// Read: req_rd/addr_rd -> data_rd/data_rdy. Write: req_wr/addr_wr/data_wr -> wr_ack.
interface fabric_xfer_if;

  logic        req_rd;
  logic [31:0] addr_rd;
  logic [31:0] data_rd;
  logic        data_rdy;
  logic        req_wr;
  logic [31:0] addr_wr;
  logic [31:0] data_wr;
  logic        wr_ack;

  modport master (
    output req_rd, addr_rd, req_wr, addr_wr, data_wr,
    input  data_rd, data_rdy, wr_ack
  );

  modport slave (
    input  req_rd, addr_rd, req_wr, addr_wr, data_wr,
    output data_rd, data_rdy, wr_ack
  );

endinterface

// File: rtl/fabric_xfer_pack.sv
// Shared shift register: unpacks weights LSB first, packs 4-bit dirs LSB first.
// Ports: clk, arst_n, ld/ld_data (load word), shift_w, shift_d/dir, q (contents).
module fabric_xfer_pack
  import fabric_pkg::*;
#(
  parameter int WEIGHT_BITS = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        ld,
  input  logic [31:0] ld_data,
  input  logic        shift_w,
  input  logic        shift_d,
  input  logic [2:0]  dir,
  output logic [31:0] q
);

  logic [31:0] sr;

  // Dirs enter at the top nibble so that after
  // eight shifts the first one sits in bits [3:0].
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr <= '0;
    end else if (ld) begin
      sr <= ld_data;
    end else if (shift_w) begin
      sr <= sr >> WEIGHT_BITS;
    end else if (shift_d) begin
      sr <= {1'b0, dir, sr[31:4]};
    end
  end

  assign q = sr;

endmodule

// File: rtl/fabric_xfer.sv
// Fabric transfer engine: loads packed weights into the node grid, runs it,
// then stores per-node dirs back. Ports: clk, arst_n, ctrl_wr/ctrl_in/ctrl_out,
// mem (bus master), node_idx/node_ld/node_weight/node_dir, fabric_run/start_idx/
// fabric_done, int_load/int_done. Macro FABRIC_XFER_DIRSTORE_EN enables dir store.
module fabric_xfer
  import fabric_pkg::*;
#(
  parameter int          GRID_LOG2   = 5,
  parameter int          WEIGHT_BITS = 4,
  parameter logic [31:0] MAP_BASE    = MAP_BASE_DFLT,
  parameter logic [31:0] DIR_BASE    = DIR_BASE_DFLT
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     ctrl_wr,
  input  logic [31:0]              ctrl_in,
  output logic [31:0]              ctrl_out,
  fabric_xfer_if.master            mem,
  output logic [2*GRID_LOG2-1:0]   node_idx,
  output logic                     node_ld,
  output logic [WEIGHT_BITS-1:0]   node_weight,
  input  logic [2:0]               node_dir,
  output logic                     fabric_run,
  output logic [2*GRID_LOG2-1:0]   start_idx,
  input  logic                     fabric_done,
  output logic                     int_load,
  output logic                     int_done
);

  localparam int G    = GRID_LOG2;
  localparam int NW   = 2 * G;
  localparam int WPW  = 32 / WEIGHT_BITS;
  localparam int KW   = $clog2(WPW);
  localparam int LDW  = ((1 << NW) * WEIGHT_BITS) / 32;
  localparam int STW  = (1 << NW) / 8;
  localparam int WCW  = $clog2(max3(LDW, STW, 2));

  state_e state, state_n;

  logic           run, load, busy;
  logic [G-1:0]   sy, sx;
  logic [NW-1:0]  idx, idx_nxt;
  logic [WCW-1:0] word;
  logic [KW-1:0]  fld;
  logic [31:0]    sr;

  logic abort;
  logic idx_clr, idx_inc;
  logic word_clr, word_inc;
  logic pack_ld, shift_w, shift_d;
  logic fire_load, fire_done;
  logic clr_load, clr_run;

  assign busy    = (state != IDLE);
  assign idx_nxt = idx + NW'(1);

  // A run/load-free write outside IDLE cancels the transfer.
  assign abort = ctrl_wr && (ctrl_in[CTRL_RUN:CTRL_LOAD] == 2'b00) && busy;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    word_clr  = 1'b0;
    word_inc  = 1'b0;
    pack_ld   = 1'b0;
    shift_w   = 1'b0;
    shift_d   = 1'b0;
    fire_load = 1'b0;
    fire_done = 1'b0;
    clr_load  = 1'b0;
    clr_run   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n  = LD_REQ;
          idx_clr  = 1'b1;
          word_clr = 1'b1;
        end else if (run) begin
          state_n = RUN;
        end
      end
      LD_REQ: state_n = LD_WAIT;
      LD_WAIT: begin
        if (mem.data_rdy) begin
          pack_ld = 1'b1;
          state_n = LD_UNPACK;
        end
      end
      LD_UNPACK: begin
        shift_w = 1'b1;
        idx_inc = 1'b1;
        if (fld == KW'(WPW - 1)) begin
          if (idx_nxt == '0) begin
            clr_load  = 1'b1;
            fire_load = 1'b1;
            state_n   = IDLE;
          end else begin
            word_inc = 1'b1;
            state_n  = LD_REQ;
          end
        end
      end
      RUN: begin
        if (fabric_done) begin
`ifdef FABRIC_XFER_DIRSTORE_EN
          idx_clr  = 1'b1;
          word_clr = 1'b1;
          state_n  = ST_GATHER;
`else
          clr_run   = 1'b1;
          fire_done = 1'b1;
          state_n   = IDLE;
`endif
        end
      end
      ST_GATHER: begin
        shift_d = 1'b1;
        idx_inc = 1'b1;
        if (idx[2:0] == 3'd7) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: state_n = ST_WAIT;
      ST_WAIT: begin
        if (mem.wr_ack) begin
          if (idx == '0) begin
            clr_run   = 1'b1;
            fire_done = 1'b1;
            state_n   = IDLE;
          end else begin
            word_inc = 1'b1;
            state_n  = ST_GATHER;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n   = IDLE;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      word_clr  = 1'b0;
      word_inc  = 1'b0;
      pack_ld   = 1'b0;
      shift_w   = 1'b0;
      shift_d   = 1'b0;
      fire_load = 1'b0;
      fire_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run  <= 1'b0;
      load <= 1'b0;
      sy   <= '0;
      sx   <= '0;
    end else if (abort) begin
      run  <= 1'b0;
      load <= 1'b0;
    end else if (ctrl_wr && !busy) begin
      run  <= ctrl_in[CTRL_RUN];
      load <= ctrl_in[CTRL_LOAD];
      sy   <= ctrl_in[CTRL_SY +: G];
      sx   <= ctrl_in[CTRL_SX +: G];
    end else begin
      if (clr_load) load <= 1'b0;
      if (clr_run)  run  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx      <= '0;
      word     <= '0;
      fld      <= '0;
      int_load <= 1'b0;
      int_done <= 1'b0;
    end else begin
      if (idx_clr) idx <= '0;
      else if (idx_inc) idx <= idx_nxt;
      if (word_clr) word <= '0;
      else if (word_inc) word <= word + WCW'(1);
      if (pack_ld) fld <= '0;
      else if (shift_w) fld <= fld + KW'(1);
      int_load <= fire_load;
      int_done <= fire_done;
    end
  end

  fabric_xfer_pack #(
    .WEIGHT_BITS(WEIGHT_BITS)
  ) u_pack (
    .clk     (clk),
    .arst_n  (arst_n),
    .ld      (pack_ld),
    .ld_data (mem.data_rd),
    .shift_w (shift_w),
    .shift_d (shift_d),
    .dir     (node_dir),
    .q       (sr)
  );

  always_comb begin
    ctrl_out = '0;
    ctrl_out[CTRL_RUN]     = run;
    ctrl_out[CTRL_LOAD]    = load;
    ctrl_out[CTRL_BUSY]    = busy;
    ctrl_out[CTRL_SY +: G] = sy;
    ctrl_out[CTRL_SX +: G] = sx;
  end

  assign mem.req_rd  = (state == LD_REQ);
  assign mem.addr_rd = (state == LD_REQ || state == LD_WAIT)
                     ? MAP_BASE + (32'(word) << 2) : '0;

`ifdef FABRIC_XFER_DIRSTORE_EN
  logic st_bus;
  assign st_bus      = (state == ST_REQ) || (state == ST_WAIT);
  assign mem.req_wr  = (state == ST_REQ);
  assign mem.addr_wr = st_bus ? DIR_BASE + (32'(word) << 2) : '0;
  assign mem.data_wr = st_bus ? sr : '0;
`else
  assign mem.req_wr  = 1'b0;
  assign mem.addr_wr = '0;
  assign mem.data_wr = '0;
`endif

  assign node_idx    = idx;
  assign node_ld     = (state == LD_UNPACK);
  assign node_weight = node_ld ? sr[WEIGHT_BITS-1:0] : '0;
  assign fabric_run  = (state == RUN);
  assign start_idx   = fabric_run ? (NW'(sy) << G) + NW'(sx) : '0;

  logic unused_ok;
  assign unused_ok = ^{ctrl_in, sr, DIR_BASE};

endmodule

// File: tb/tb_fabric_xfer.sv
// Scoreboard bench for fabric_xfer at GRID_LOG2=2, WEIGHT_BITS=4.
// Stimulus pushes expected events; negedge monitors pop and compare.
module tb_fabric_xfer;

  localparam int G  = 2;
  localparam int WB = 4;
  localparam int NW = 2 * G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n = 1'b0;
  logic          ctrl_wr = 1'b0;
  logic [31:0]   ctrl_in = '0;
  logic [31:0]   ctrl_out;
  logic [NW-1:0] node_idx;
  logic          node_ld;
  logic [WB-1:0] node_weight;
  logic [2:0]    node_dir;
  logic          fabric_run;
  logic [NW-1:0] start_idx;
  logic          fabric_done = 1'b0;
  logic          int_load, int_done;

  logic          resp_rdy = 1'b0;
  logic          stray_rdy = 1'b0;
  logic [31:0]   resp_data = '0;
  logic          wr_ack = 1'b0;
  logic          no_ack = 1'b0;
  logic          run_prev = 1'b0;

  fabric_xfer_if mem();

  assign mem.data_rdy = resp_rdy | stray_rdy;
  assign mem.data_rd  = resp_data;
  assign mem.wr_ack   = wr_ack;
  assign node_dir     = node_idx[2:0];

  fabric_xfer #(
    .GRID_LOG2   (G),
    .WEIGHT_BITS (WB)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .ctrl_wr     (ctrl_wr),
    .ctrl_in     (ctrl_in),
    .ctrl_out    (ctrl_out),
    .mem         (mem),
    .node_idx    (node_idx),
    .node_ld     (node_ld),
    .node_weight (node_weight),
    .node_dir    (node_dir),
    .fabric_run  (fabric_run),
    .start_idx   (start_idx),
    .fabric_done (fabric_done),
    .int_load    (int_load),
    .int_done    (int_done)
  );

  logic [31:0]   rd_q[$];
  logic [31:0]   rdat_q[$];
  int            rdly_q[$];
  logic [63:0]   wr_q[$];
  logic [7:0]    nd_q[$];
  int            irq_q[$];
  logic [NW-1:0] st_q[$];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexp(string nm, logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected event %0h, expected none", nm, act);
  endfunction

  function automatic int pending();
    return rd_q.size() + wr_q.size() + nd_q.size() + irq_q.size() + st_q.size();
  endfunction

  always @(negedge clk) begin : mon
    logic [63:0] w;
    if (mem.req_rd) begin
      if (rd_q.size() == 0) unexp("rd_addr", mem.addr_rd);
      else chk("rd_addr", mem.addr_rd, rd_q.pop_front());
    end
    if (mem.req_wr) begin
      if (wr_q.size() == 0) unexp("wr_req", mem.addr_wr);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", mem.addr_wr, w[63:32]);
        chk("wr_data", mem.data_wr, w[31:0]);
      end
    end
    if (node_ld) begin
      if (nd_q.size() == 0) unexp("node_ld", {node_idx, node_weight});
      else chk("node_ld", {node_idx, node_weight}, nd_q.pop_front());
    end
    if (int_load) begin
      if (irq_q.size() == 0) unexp("int_load", 1);
      else chk("int_load", 1, irq_q.pop_front());
    end
    if (int_done) begin
      if (irq_q.size() == 0) unexp("int_done", 2);
      else chk("int_done", 2, irq_q.pop_front());
    end
    if (fabric_run && !run_prev) begin
      if (st_q.size() == 0) unexp("start_idx", start_idx);
      else chk("start_idx", start_idx, st_q.pop_front());
    end
    run_prev <= fabric_run;
  end

  initial begin : rd_resp
    logic [31:0] d;
    int dl;
    forever begin
      @(negedge clk);
      if (mem.req_rd && rdat_q.size() != 0) begin
        d  = rdat_q.pop_front();
        dl = rdly_q.pop_front();
        @(posedge clk); #1;
        repeat (dl) begin @(posedge clk); #1; end
        resp_data = d;
        resp_rdy  = 1'b1;
        @(posedge clk); #1;
        resp_rdy  = 1'b0;
      end
    end
  end

  initial begin : wr_resp
    forever begin
      @(negedge clk);
      if (mem.req_wr && !no_ack) begin
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        wr_ack = 1'b1;
        @(posedge clk); #1;
        wr_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    ctrl_in = v;
    ctrl_wr = 1'b1;
    tick();
    ctrl_wr = 1'b0;
    ctrl_in = '0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    while ((pending() != 0 || ctrl_out[29]) && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_in_time"}, (k < budget), 1);
    tick(3);
    chk({nm, "_left"}, pending(), 0);
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (!fabric_run && k < 50) begin
      tick();
      k++;
    end
    chk("run_seen", fabric_run, 1);
  endtask

  task automatic push_load(input int dly);
    for (int i = 0; i < 16; i++) nd_q.push_back({4'(i), 4'(i)});
    rd_q.push_back(32'h4000_0000);
    rd_q.push_back(32'h4000_0004);
    rdat_q.push_back(32'h7654_3210);
    rdly_q.push_back(dly);
    rdat_q.push_back(32'hFEDC_BA98);
    rdly_q.push_back(dly);
    irq_q.push_back(1);
  endtask

  task automatic check_outs_zero(input string nm);
    chk({nm, "_ctrl"}, ctrl_out, 0);
    chk({nm, "_outs"}, |{mem.req_rd, mem.addr_rd, mem.req_wr, mem.addr_wr,
                         mem.data_wr, node_idx, node_ld, node_weight,
                         fabric_run, start_idx, int_load, int_done}, 0);
  endtask

  initial begin : stim
    int k;
    tick(2);
    check_outs_zero("reset");
    arst_n = 1'b1;
    tick(2);

    push_load(0);
    wr_ctrl(32'h4000_0000);
    wait_drain("load", 200);
    chk("load_ctrl", ctrl_out, 32'h0);

    stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    tick(2);
    chk("stray_idle", ctrl_out, 32'h0);
    push_load(5);
    wr_ctrl(32'h4000_0000);
    wait_drain("load_dly", 300);
    chk("load_dly_ctrl", ctrl_out, 32'h0);

    for (int i = 0; i < 8; i++) nd_q.push_back({4'(i), 4'(i)});
    rd_q.push_back(32'h4000_0000);
    rd_q.push_back(32'h4000_0004);
    rdat_q.push_back(32'h7654_3210);
    rdly_q.push_back(0);
    rdat_q.push_back(32'hFEDC_BA98);
    rdly_q.push_back(12);
    wr_ctrl(32'h4000_0000);
    tick(2);
    wr_ctrl(32'hC000_0000);
    chk("ignored_wr", ctrl_out[31:29], 3'b011);
    k = 0;
    while ((rd_q.size() != 0 || nd_q.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    chk("abort_reach", (k < 100), 1);
    wr_ctrl(32'h0000_0000);
    chk("abort_ctrl", ctrl_out, 32'h0);
    tick(25);
    chk("abort_left", pending(), 0);

`ifdef FABRIC_XFER_DIRSTORE_EN
    st_q.push_back(NW'(5));
    wr_q.push_back({32'h4000_2000, 32'h7654_3210});
    wr_q.push_back({32'h4000_2004, 32'h7654_3210});
    irq_q.push_back(2);
    wr_ctrl(32'h8000_0401);
    wait_run();
    tick(3);
    fabric_done = 1'b1;
    tick();
    fabric_done = 1'b0;
    wait_drain("store", 300);
    chk("store_ctrl", ctrl_out, 32'h0000_0401);

    st_q.push_back(NW'(5));
    wr_q.push_back({32'h4000_2000, 32'h7654_3210});
    no_ack = 1'b1;
    wr_ctrl(32'h8000_0401);
    wait_run();
    tick(2);
    fabric_done = 1'b1;
    tick();
    fabric_done = 1'b0;
    k = 0;
    while (wr_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk("st_wait_reach", (k < 100), 1);
    tick(2);
    arst_n = 1'b0;
    #1;
    check_outs_zero("rst_st_wait");
    tick();
    arst_n = 1'b1;
    no_ack = 1'b0;
    tick(10);
    chk("rst_st_left", pending(), 0);
`else
    st_q.push_back(NW'(5));
    irq_q.push_back(2);
    wr_ctrl(32'h8000_0401);
    wait_run();
    tick(3);
    fabric_done = 1'b1;
    tick();
    fabric_done = 1'b0;
    chk("int_done_next", int_done, 1);
    wait_drain("run_nostore", 50);
    chk("run_ctrl", ctrl_out, 32'h0000_0401);

    for (int i = 0; i < 8; i++) nd_q.push_back({4'(i), 4'(i)});
    rd_q.push_back(32'h4000_0000);
    rd_q.push_back(32'h4000_0004);
    rdat_q.push_back(32'h7654_3210);
    rdly_q.push_back(0);
    wr_ctrl(32'h4000_0000);
    k = 0;
    while ((rd_q.size() != 0 || nd_q.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    chk("rst_ld_reach", (k < 100), 1);
    arst_n = 1'b0;
    #1;
    check_outs_zero("rst_load");
    tick();
    arst_n = 1'b1;
    tick(10);
    chk("rst_ld_left", pending(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fabric_xfer.md
FABRIC_XFER -- requirements
Module: fabric_xfer

Interface
REQ-001 SHALL have parameter GRID_LOG2, default 5, meaning grid side 2^GRID_LOG2 and node count N=4^GRID_LOG2 (legal 2..10).
REQ-002 SHALL have parameter WEIGHT_BITS, default 4, meaning weight field width (legal 1,2,4,8,16) with WPW=32/WEIGHT_BITS weights per word.
REQ-003 SHALL have parameters MAP_BASE, default 32'h40000000, and DIR_BASE, default 32'h40002000, meaning the map and direction region byte bases.
REQ-004 SHALL have ports, clock and reset first: clk in 1 clock; arst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: ctrl_wr in 1 register write strobe; ctrl_in in 32 write data; ctrl_out out 32 register readback.
REQ-006 SHALL have ports: req_rd out 1 read request pulse; addr_rd out 32; data_rd in 32; data_rdy in 1 read data valid.
REQ-007 SHALL have ports: req_wr out 1 write request pulse; addr_wr out 32; data_wr out 32; wr_ack in 1 write complete.
REQ-008 SHALL have ports: node_idx out 2*GRID_LOG2; node_ld out 1; node_weight out WEIGHT_BITS; node_dir in 3 (dir of node_idx, combinational); fabric_run out 1; start_idx out 2*GRID_LOG2; fabric_done in 1.
REQ-009 SHALL have ports: int_load out 1 and int_done out 1, single-cycle pulses.

Function
REQ-010 ctrl layout SHALL be: [31] run, [30] load, [29] busy (read-only), [19:10] start_y, [9:0] start_x; start fields use the low GRID_LOG2 bits; other bits read 0.
REQ-011 ctrl_wr SHALL be accepted only in IDLE, except that a write with [31:30]=00 in any state aborts: state to IDLE, run/load cleared, no interrupt.
REQ-012 States SHALL be IDLE, LD_REQ, LD_WAIT, LD_UNPACK, RUN, ST_GATHER, ST_REQ, ST_WAIT; busy=1 outside IDLE.
REQ-013 IDLE: load=1 -> LD_REQ with node_idx=0 and word=0; else run=1 -> RUN; load has priority when both are set.
REQ-014 LD_REQ: req_rd=1 for one cycle with addr_rd=MAP_BASE+4*word -> LD_WAIT.
REQ-015 LD_WAIT: data_rdy is sampled from the cycle after req_rd; on data_rdy latch data_rd -> LD_UNPACK; data_rdy in any other state is ignored.
REQ-016 LD_UNPACK: one node per cycle; node_ld=1, node_weight=field k (bits k*WEIGHT_BITS upward, LSB first), node_idx increments.
REQ-017 After field WPW-1: if node_idx wrapped to 0 (all N loaded), clear load, pulse int_load, -> IDLE; else word+1 -> LD_REQ.
REQ-018 RUN: fabric_run=1 held, start_idx=(start_y<<GRID_LOG2)+start_x; on fabric_done, node_idx=0, word=0 -> ST_GATHER.
REQ-019 ST_GATHER: over 8 cycles, pack node_dir zero-extended to 4 bits into nibble (node_idx mod 8), LSB first, then node_idx increments -> ST_REQ.
REQ-020 ST_REQ: req_wr=1 for one cycle, addr_wr=DIR_BASE+4*word, data_wr=packed word held until wr_ack -> ST_WAIT.
REQ-021 ST_WAIT: on wr_ack, if node_idx wrapped to 0, clear run, pulse int_done, -> IDLE; else word+1 -> ST_GATHER.
REQ-022 Address arithmetic SHALL be 32-bit with wrap; word counter width SHALL be sized for N*WEIGHT_BITS/32 and N/8 words.

Reset
REQ-023 On arst_n low all outputs SHALL be 0, the state IDLE, and ctrl fields 0; a reset mid-transfer abandons it with no interrupt.

Configuration
REQ-024 Macro FABRIC_XFER_DIRSTORE_EN defined: store phase per REQ-019..021.
REQ-025 Macro FABRIC_XFER_DIRSTORE_EN undefined: fabric_done clears run, pulses int_done, -> IDLE; req_wr, addr_wr and data_wr are constant 0.

Structure
REQ-026 Package fabric_pkg SHALL hold the state enum, ctrl bit positions and default MAP_BASE/DIR_BASE.
REQ-027 One sub-module fabric_xfer_pack SHALL hold the shift register for unpacking weights and packing dirs.

Verification (GRID_LOG2=2, WEIGHT_BITS=4)
REQ-028 ctrl 0x40000000, data 0x76543210 then 0xFEDCBA98 -> reads at 0x40000000/0x40000004, node_ld idx 0..15 with weights 0..F, one int_load pulse, ctrl_out[30]=0.
REQ-029 data_rdy delayed 5 cycles and a stray data_rdy in IDLE -> no extra node_ld, results as REQ-028.
REQ-030 ctrl 0x80000401 (y=1, x=1), fabric_done, node_dir=idx mod 8 -> start_idx=5, writes 0x76543210 to 0x40002000 and 0x40002004, int_done.
REQ-031 Writes of ctrl 0xC0000000 during load are ignored; a write of 0x00000000 after the first word -> IDLE, no int_load, busy=0.
REQ-032 Macro undefined: run, fabric_done -> int_done the next cycle, req_wr never 1.
REQ-033 arst_n low during ST_WAIT -> all outputs 0, ctrl_out=0.
